sort4_stream_ctrl: RTL

//  Streaming front end for the 4-input descending sorter datapath.
//  - Collects up to 4 words arriving serially on a valid/ready input.
//  - Runs one group through a single combinational sorter instance.
//  - Returns the group serially, largest first, on a valid/ready output.
//  - Sits between a word-serial producer and consumer so they can share one sorter.

---
 rtl/sort4_pkg.sv | 16 +
 rtl/sort4_desc_core.sv | 36 +++
 rtl/sort4_stream_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/sort4_pkg.sv
// Shared definitions for the 4-word streaming descending sorter:
// lane count, default data width and the controller state encoding.
package sort4_pkg;

  localparam int N_LANES       = 4;
  localparam int DEFAULT_WIDTH = 16;

  // Encoding 2'd3 is unused; the controller treats it as a fault and
  // returns to FILL.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sort4_desc_core.sv
// Combinational 4-input unsigned sorter producing y0 >= y1 >= y2 >= y3.
// Five compare-exchange elements in three layers: sort the two pairs,
// merge the extremes, then order the two middle candidates.
module sort4_desc_core
  import sort4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3
);

  logic [WIDTH-1:0] hi_ab, lo_ab, hi_cd, lo_cd;
  logic [WIDTH-1:0] mid_hi, mid_lo;

  // Compare-exchange network; every layer picks max/min of two values.
  always_comb begin
    hi_ab  = (a >= b) ? a : b;
    lo_ab  = (a >= b) ? b : a;
    hi_cd  = (c >= d) ? c : d;
    lo_cd  = (c >= d) ? d : c;
    y0     = (hi_ab >= hi_cd) ? hi_ab : hi_cd;
    mid_hi = (hi_ab >= hi_cd) ? hi_cd : hi_ab;
    mid_lo = (lo_ab >= lo_cd) ? lo_ab : lo_cd;
    y3     = (lo_ab >= lo_cd) ? lo_cd : lo_ab;
    y1     = (mid_hi >= mid_lo) ? mid_hi : mid_lo;
    y2     = (mid_hi >= mid_lo) ? mid_lo : mid_hi;
  end

endmodule

// File: rtl/sort4_stream_ctrl.sv
// Streaming front end for the 4-input descending sorter. Words arrive
// serially, are parked in slot registers, sorted in one SORT cycle into
// obuf, and then returned largest first. Input and output phases never
// overlap, so a single sorter instance serves the whole stream.
module sort4_stream_ctrl
  import sort4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] grp_cnt
);

  state_t           state;
  logic [1:0]       idx;
  logic [1:0]       k;
  logic [2:0]       n;
  logic [WIDTH-1:0] slot [N_LANES];
  logic [WIDTH-1:0] obuf [N_LANES];
  logic [WIDTH-1:0] y0, y1, y2, y3;

  // Unfilled slots are zero, and zero pads always sort to the tail, so
  // obuf[0..n-1] holds exactly the real words of a short group.
  sort4_desc_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a  (slot[0]),
    .b  (slot[1]),
    .c  (slot[2]),
    .d  (slot[3]),
    .y0 (y0),
    .y1 (y1),
    .y2 (y2),
    .y3 (y3)
  );

  // A group is in progress once any word is parked or the FSM has left FILL.
  assign busy = (state != FILL) || (idx != 2'd0);

  // Controller FSM: fill slots, sort once, drain obuf with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      idx       <= 2'd0;
      k         <= 2'd0;
      n         <= 3'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      grp_cnt   <= '0;
      for (int i = 0; i < N_LANES; i++) begin
        slot[i] <= '0;
        obuf[i] <= '0;
      end
    end else begin
      case (state)
        FILL: begin
          if (in_valid && in_ready) begin
            slot[idx] <= in_data;
            idx       <= idx + 2'd1;
            // idx wraps to 0 on the fourth word; busy still holds via state.
            if (idx == 2'd3 || in_last) begin
              n        <= {1'b0, idx} + 3'd1;
              state    <= SORT;
              in_ready <= 1'b0;
            end
          end
        end

        SORT: begin
          obuf[0]   <= y0;
          obuf[1]   <= y1;
          obuf[2]   <= y2;
          obuf[3]   <= y3;
          k         <= 2'd0;
          out_valid <= 1'b1;
          out_data  <= y0;
          out_last  <= (n == 3'd1);
          state     <= DRAIN;
        end

        DRAIN: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= FILL;
              idx       <= 2'd0;
              k         <= 2'd0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              grp_cnt   <= grp_cnt + CNT_W'(1);
              for (int i = 0; i < N_LANES; i++) begin
                slot[i] <= '0;
              end
            end else begin
              k        <= k + 2'd1;
              out_data <= obuf[k + 2'd1];
              // Next word is the last when (k+1) == n-1.
              out_last <= (({1'b0, k} + 3'd2) == n);
            end
          end
        end

        default: begin
          state     <= FILL;
          idx       <= 2'd0;
          k         <= 2'd0;
          n         <= 3'd0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          for (int i = 0; i < N_LANES; i++) begin
            slot[i] <= '0;
          end
        end
      endcase
    end
  end

endmodule
